// File: rtl/wavelet_sched.sv
// Front-end sequencer for a bank of FIR wavelet filters: owns the shared tap delay
// line, strobes each filter in turn after every decimation period, serializes results.
module wavelet_sched #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int NUM_ELEM       = 7,
    parameter int NUM_FILTERS    = 4,
    parameter int SUM_TRUNCATION = 8,
    parameter int DECIMATE       = 1,
    localparam int IDX_W         = (NUM_FILTERS > 2) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [BITS_PER_ELEM-1:0]          i_sample,
    input  logic                                     i_sample_valid,
    output logic                                     o_sample_ready,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0]        o_taps,
    output logic [NUM_FILTERS-1:0]                   o_start_calc,
    input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0]    i_wavelets,
    output logic signed [SUM_TRUNCATION-1:0]         o_data,
    output logic [IDX_W-1:0]                         o_data_idx,
    output logic                                     o_data_valid,
    input  logic                                     i_data_ready,
    output logic                                     o_busy
);

    localparam int TAP_W = NUM_ELEM * BITS_PER_ELEM;
    localparam int CNT_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATE - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  dec_cnt;
    logic [IDX_W-1:0]  k;
    logic              accept;
    logic              dec_wrap;
    logic              handshake;
    logic              k_last;
    logic [TAP_W-1:0]  taps_shift;

    function automatic logic signed [SUM_TRUNCATION-1:0] pick_wavelet(
        input logic [NUM_FILTERS*SUM_TRUNCATION-1:0] w,
        input logic [IDX_W-1:0]                      idx
    );
        return w[int'(idx)*SUM_TRUNCATION +: SUM_TRUNCATION];
    endfunction

    assign accept    = (state == S_IDLE) && i_sample_valid;
    assign dec_wrap  = (dec_cnt == CNT_LAST);
    assign handshake = (state == S_OUT) && i_data_ready;
    assign k_last    = (k == K_LAST);

    // Ready only in IDLE keeps the taps frozen while the filters compute.
    assign o_sample_ready = (state == S_IDLE);
    assign o_busy         = (state != S_IDLE);
    assign o_start_calc   = (state == S_CALC) ? (NUM_FILTERS'(1) << k) : '0;

    always_comb begin
        taps_shift                    = o_taps << BITS_PER_ELEM;
        taps_shift[BITS_PER_ELEM-1:0] = i_sample;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && dec_wrap) state_nxt = S_CALC;
            S_CALC: state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_OUT;
            S_OUT:  if (handshake) state_nxt = k_last ? S_IDLE : S_CALC;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_cnt <= '0;
            k       <= '0;
        end else if (accept) begin
            dec_cnt <= dec_wrap ? '0 : dec_cnt + 1'b1;
            if (dec_wrap) k <= '0;
        end else if (handshake) begin
            k <= k_last ? '0 : k + 1'b1;
        end
    end

    // Filter registered its sum on CALC->WAIT; capture it at the end of WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_taps       <= '0;
            o_data       <= '0;
            o_data_idx   <= '0;
            o_data_valid <= 1'b0;
        end else begin
            if (accept) o_taps <= taps_shift;
            if (state == S_WAIT) begin
                o_data       <= pick_wavelet(i_wavelets, k);
                o_data_idx   <= k;
                o_data_valid <= 1'b1;
            end else if (handshake) begin
                o_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/wavelet_sched.md
Name: wavelet_sched

Overview:
- Front-end sequencer for the bank of FIR wavelet filters.
- Accepts input samples over a valid/ready handshake and maintains the shared tap delay line that drives every filter's taps input.
- After each decimation period it fires each filter's start-calc strobe in turn and captures that filter's truncated wavelet output.
- Emits the captured results as one serialized, tagged output stream with backpressure.

Parameters:
- BITS_PER_ELEM, 8: sample width, equal to the FIR element width.
- NUM_ELEM, 7: tap count, equal to the FIR element count.
- NUM_FILTERS, 4: number of FIR instances scheduled; must be 2 or more.
- SUM_TRUNCATION, 8: width of each filter's wavelet output.
- DECIMATE, 1: compute once every DECIMATE accepted samples; must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_sample  in  BITS_PER_ELEM  input sample, signed.
- i_sample_valid  in  1  i_sample is valid.
- o_sample_ready  out  1  scheduler can accept a sample.
- o_taps  out  NUM_ELEM*BITS_PER_ELEM  delay line; element 0 (bits [BITS_PER_ELEM-1:0]) is the newest sample.
- o_start_calc  out  NUM_FILTERS  one-hot start strobe; bit k drives filter k.
- i_wavelets  in  NUM_FILTERS*SUM_TRUNCATION  concatenated filter outputs; filter k occupies slice k.
- o_data  out  SUM_TRUNCATION  captured wavelet value.
- o_data_idx  out  max(1,$clog2(NUM_FILTERS))  index of the filter that produced o_data.
- o_data_valid  out  1  o_data and o_data_idx are valid.
- i_data_ready  in  1  downstream accepts o_data.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous, takes effect without a clock edge):
  - o_taps = 0, o_start_calc = 0, o_data = 0, o_data_idx = 0, o_data_valid = 0.
  - State = IDLE, decimation count = 0, filter index k = 0.
  - o_sample_ready = 1 and o_busy = 0 while held in reset and after release.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- o_sample_ready is 1 only in IDLE, so taps are frozen for the whole calculation sequence.
- A sample is accepted on a rising edge where i_sample_valid && o_sample_ready. On acceptance:
  - o_taps shifts left by BITS_PER_ELEM and i_sample enters element 0. The oldest element is discarded.
  - The decimation count increments.
  - If the count was DECIMATE-1, it wraps to 0, k is set to 0, and the state goes to CALC. Otherwise the state stays IDLE.
- States:
  - IDLE: waits for an accepted sample.
  - CALC: o_start_calc = one-hot(k) for exactly one cycle. Next state is WAIT.
  - WAIT: the filter registers its sum on the CALC-to-WAIT edge. At the end of WAIT, o_data <= slice k of i_wavelets, o_data_idx <= k, o_data_valid <= 1. Next state is OUT.
  - OUT: o_data, o_data_idx and o_data_valid are held stable until i_data_ready = 1. On that handshake edge:
    - o_data_valid <= 0.
    - If k == NUM_FILTERS-1: next state is IDLE and k <= 0.
    - Otherwise: k <= k+1 and next state is CALC.
- Latency:
  - Acceptance at edge E0: start bit 0 is high in the cycle after E0.
  - o_data_valid for filter 0 rises at E2.
  - With i_data_ready held at 1, each filter costs 3 cycles. The full sequence returns to IDLE 3*NUM_FILTERS edges after E0.
- Exactly one o_start_calc bit is high at a time, and only ever in CALC. o_start_calc = 0 in all other states.
- Arithmetic: o_data is copied from i_wavelets without modification, and the result is signed. The decimation count and k wrap as stated; they never exceed DECIMATE-1 and NUM_FILTERS-1.
- Simultaneous events: i_sample_valid while not in IDLE is ignored. The sample stays pending upstream and is not lost.
- Reset in any state aborts the sequence. No partial output is emitted after reset release.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, o_sample_ready=1; after release, o_busy=0.
- Single sample, NUM_FILTERS=2, DECIMATE=1, bench FIR model gives i_wavelets={0x22,0x11}, i_data_ready=1. Accept 0x05 -> required response:
  - o_taps[7:0]=0x05.
  - o_start_calc=01 for one cycle, then o_data=0x11 with idx 0.
  - Then o_start_calc=10 for one cycle, then o_data=0x22 with idx 1.
  - o_sample_ready returns to 1 six edges after acceptance.
- Shift, NUM_ELEM=7: feed 0x01..0x08 -> o_taps elements 0..6 = 0x08,0x07,...,0x02; 0x01 is discarded.
- Backpressure: i_data_ready=0 for 5 cycles in OUT with k=0 -> o_data, o_data_idx and o_data_valid are held; no o_start_calc pulse; o_sample_ready=0; sequence resumes on i_data_ready=1.
- DECIMATE=3: accept 6 samples -> exactly two calculation sequences, triggered after samples 3 and 6; no start pulses after the other samples.
- Async reset mid-OUT: drop rst with o_data_valid=1 -> o_data_valid=0 and o_taps=0 before the next clock edge; after release the scheduler is in IDLE with no residual output.
